// File: rtl/config_loader_pkg.sv
// Shared definitions for the fabric configuration loader: FSM encoding and
// the configuration chain length derived from the 3x3 mesh composition.
package config_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int MESH_DIM   = 3;
  localparam int IO_COUNT   = 4 * MESH_DIM;
  localparam int IO_BITS    = 16;
  localparam int CLB_COUNT  = MESH_DIM * MESH_DIM;
  localparam int CLB_BITS   = 291;
  localparam int CX_COUNT   = 2 * MESH_DIM * (MESH_DIM + 1);
  localparam int CX_BITS    = 32;
  localparam int SWBX_COUNT = (MESH_DIM + 1) * (MESH_DIM + 1);
  localparam int SWBX_BITS  = 67;

  // Chain order is IO, CLB, connection boxes, switch boxes; only the total matters here.
  function automatic int fabric_config_width();
    return IO_COUNT * IO_BITS + CLB_COUNT * CLB_BITS +
           CX_COUNT * CX_BITS + SWBX_COUNT * SWBX_BITS;
  endfunction

  localparam int FABRIC_CONFIG_WIDTH = fabric_config_width();

endpackage

// File: rtl/config_loader_cfg_clk_div.sv
// Configuration shift-clock generator: divides clk by 2*CLK_DIV while enabled,
// held low and cleared while disabled, with strobes marking the coming edges.
module cfg_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic sys_reset,
  input  logic en_i,
  output logic cfg_clk_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] TERM = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          clk_q, clk_d;
  logic          term_s;

  assign term_s = (cnt_q == TERM);

  // Strobes are high in the cycle whose closing clk edge toggles cfg_clk.
  assign rise_stb_o = en_i & term_s & ~clk_q;
  assign fall_stb_o = en_i & term_s & clk_q;
  assign cfg_clk_o  = clk_q;

  // Half-period counter and shift clock next state.
  always_comb begin
    cnt_d = cnt_q;
    clk_d = clk_q;
    if (!en_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (term_s) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end else begin
      cnt_d = cnt_q + DW'(1);
      clk_d = clk_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

endmodule

// File: rtl/config_loader.sv
// Serialises a word-fed bitstream MSB-first into the fabric configuration chain
// and returns the chain's previous contents as left-aligned readback words.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int CONFIG_WIDTH = FABRIC_CONFIG_WIDTH,
  parameter int WORD_WIDTH   = 32,
  parameter int CLK_DIV      = 2
) (
  input  logic                  clk,
  input  logic                  sys_reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid,
  output logic                  config_clk,
  output logic                  config_en,
  output logic                  config_in,
  input  logic                  config_out
);

  localparam int CW = $clog2(CONFIG_WIDTH + 1);
  localparam int IW = $clog2(WORD_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(CONFIG_WIDTH - 1);
  localparam logic [IW-1:0] WORD_LAST = IW'(WORD_WIDTH - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [WORD_WIDTH-1:0] rb_acc_q, rb_acc_d;
  logic [WORD_WIDTH-1:0] rb_data_q, rb_data_d;
  logic                  rb_valid_q, rb_valid_d;
  logic                  busy_q, busy_d;
  logic                  en_q, en_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic                  shift_en_s, rise_stb_s, fall_stb_s, word_end_s;

  assign shift_en_s = (state_q == ST_SHIFT);

  cfg_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk       (clk),
    .sys_reset (sys_reset),
    .en_i      (shift_en_s),
    .cfg_clk_o (config_clk),
    .rise_stb_o(rise_stb_s),
    .fall_stb_o(fall_stb_s)
  );

  // A word ends on its last bit or on the final bit of the chain (short last word).
  assign word_end_s = (idx_q == WORD_LAST) || (bit_cnt_q == LAST_BIT);

  // Session FSM, shift/readback datapath and registered output decode.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    rb_acc_d   = rb_acc_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          bit_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (word_valid && ready_q) begin
          state_d  = ST_SHIFT;
          shift_d  = word_data;
          idx_d    = '0;
          rb_acc_d = '0;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_SHIFT: begin
        if (rise_stb_s) begin
          rb_acc_d = {rb_acc_q[WORD_WIDTH-2:0], config_out};
        end else if (fall_stb_s) begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          idx_d     = idx_q + IW'(1);
          shift_d   = {shift_q[WORD_WIDTH-2:0], 1'b0};
          if (word_end_s) begin
            // Left-align a partial capture so unused low bits read as zero.
            rb_valid_d = 1'b1;
            rb_data_d  = rb_acc_q << (WORD_LAST - idx_q);
            shift_d    = '0;
            state_d    = (bit_cnt_q == LAST_BIT) ? ST_DONE : ST_LOAD;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    en_d    = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_LOAD);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      rb_acc_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      rb_acc_q   <= rb_acc_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
      busy_q     <= busy_d;
      en_q       <= en_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign word_ready = ready_q;
  assign rb_data    = rb_data_q;
  assign rb_valid   = rb_valid_q;
  assign config_en  = en_q;
  assign config_in  = shift_q[WORD_WIDTH-1];

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: 40-bit chain, 16-bit words, CLK_DIV=1,
// fabric modelled as a 40-bit shift register clocked by config_clk.
module tb_config_loader;

  logic        clk = 1'b0;
  logic        sys_reset, start, word_valid, config_out;
  logic [15:0] word_data, rb_data;
  logic        busy, done, word_ready, rb_valid, config_clk, config_en, config_in;

  logic [39:0] fab_q = '0;
  logic [39:0] preload_val = '0;
  logic        load_pulse = 1'b0;

  int checks = 0;
  int failures = 0;
  int rises = 0;
  int acc_cnt = 0;
  int busy_cnt = 0;
  int rb_cnt = 0;
  int base_rises = 0;
  bit post_done_chk = 1'b0;

  typedef struct {
    logic [39:0] chain;
    int          cycles;
  } done_exp_t;

  logic [15:0] exp_rb[$];
  done_exp_t   exp_done[$];

  always #5 clk = ~clk;

  config_loader #(
    .CONFIG_WIDTH(40),
    .WORD_WIDTH  (16),
    .CLK_DIV     (1)
  ) dut (
    .clk       (clk),
    .sys_reset (sys_reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid),
    .config_clk(config_clk),
    .config_en (config_en),
    .config_in (config_in),
    .config_out(config_out)
  );

  // Fabric chain model: tail bit feeds back as config_out.
  assign config_out = fab_q[39];
  always @(posedge config_clk or posedge load_pulse) begin
    if (load_pulse) fab_q <= preload_val;
    else if (config_en) fab_q <= {fab_q[38:0], config_in};
  end

  always @(posedge config_clk) rises <= rises + 1;
  always @(posedge clk) if (word_valid && word_ready) acc_cnt <= acc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout/unexpected required=event", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents rb_valid or done.
  initial begin
    done_exp_t d;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (post_done_chk) begin
        chk("idle_after_done_busy", 64'(busy), 64'd0);
        chk("idle_after_done_en", 64'(config_en), 64'd0);
        post_done_chk = 1'b0;
      end
      if (busy) busy_cnt++;
      else begin
        busy_cnt = 0;
        rb_cnt = 0;
        base_rises = rises;
      end
      if (word_ready) chk("clk_low_in_load", 64'(config_clk), 64'd0);
      if (rb_valid) begin
        rb_cnt++;
        if (exp_rb.size() == 0) fail_now("rb_unexpected");
        else begin
          e = exp_rb.pop_front();
          chk("rb_data", 64'(rb_data), 64'(e));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) fail_now("done_unexpected");
        else begin
          d = exp_done.pop_front();
          chk("chain", 64'(fab_q), 64'(d.chain));
          chk("rises", 64'(rises - base_rises), 64'd40);
          chk("busy_cycles", 64'(busy_cnt), 64'(d.cycles));
          chk("rb_pulses", 64'(rb_cnt), 64'd3);
          chk("en_at_done", 64'(config_en), 64'd1);
          post_done_chk = 1'b1;
        end
      end
    end
  end

  task automatic all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_ready"}, 64'(word_ready), 64'd0);
    chk({tag, "_rb_data"}, 64'(rb_data), 64'd0);
    chk({tag, "_rb_valid"}, 64'(rb_valid), 64'd0);
    chk({tag, "_cfg_clk"}, 64'(config_clk), 64'd0);
    chk({tag, "_cfg_en"}, 64'(config_en), 64'd0);
    chk({tag, "_cfg_in"}, 64'(config_in), 64'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic preload_model(input logic [39:0] v);
    preload_val = v;
    load_pulse = 1'b1;
    #1;
    load_pulse = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    int n = 0;
    int a0;
    while (!word_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!word_ready) begin
      fail_now("word_ready_wait");
      return;
    end
    repeat (gap) @(negedge clk);
    word_data = w;
    word_valid = 1'b1;
    a0 = acc_cnt;
    n = 0;
    while (acc_cnt == a0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    word_valid = 1'b0;
    word_data = '0;
    if (acc_cnt == a0) fail_now("word_accept_wait");
  endtask

  task automatic push_expect(input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2,
                             input logic [39:0] chain, input int cycles);
    done_exp_t d;
    exp_rb.push_back(r0);
    exp_rb.push_back(r1);
    exp_rb.push_back(r2);
    d.chain = chain;
    d.cycles = cycles;
    exp_done.push_back(d);
  endtask

  task automatic feed_words(input logic [47:0] w, input int gap, input bit glitch);
    send_word(w[47:32], 0);
    if (glitch) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    send_word(w[31:16], gap);
    send_word(w[15:0], gap);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail_now(name);
  endtask

  task automatic run_session(input string name, input logic [39:0] pre, input logic [47:0] w,
                             input int gap, input bit glitch, input logic [39:0] chain,
                             input logic [47:0] rb, input int cycles);
    repeat (2) @(negedge clk);
    preload_model(pre);
    push_expect(rb[47:32], rb[31:16], rb[15:0], chain, cycles);
    pulse_start();
    feed_words(w, gap, glitch);
    wait_done(name);
  endtask

  initial begin
    int base;
    int n;
    sys_reset = 1'b0;
    start = 1'b0;
    word_valid = 1'b0;
    word_data = '0;

    // 1. Reset values, asynchronous reset mid-session, restart.
    #12;
    all_zero("por");
    @(negedge clk);
    sys_reset = 1'b1;
    pulse_start();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_ready", 64'(word_ready), 64'd1);
    @(posedge clk);
    #2;
    sys_reset = 1'b0;
    #1;
    all_zero("reset_mid");
    @(negedge clk);
    sys_reset = 1'b1;
    pulse_start();
    chk("t1_restart_ready", 64'(word_ready), 64'd1);
    @(negedge clk);
    sys_reset = 1'b0;
    @(negedge clk);
    sys_reset = 1'b1;

    // 2. Full load.
    run_session("t2_done", 40'h01_2345_6789, 48'hA5F0_1234_C0FF, 0, 1'b0,
                40'hA5F0_1234_C0, 48'h0123_4567_8900, 84);
    // 3. Backpressure before words 2 and 3: ten extra cycles.
    run_session("t3_done", 40'hA5F0_1234_C0, 48'hA5F0_1234_C0FF, 5, 1'b0,
                40'hA5F0_1234_C0, 48'hA5F0_1234_C000, 94);
    // 4. Readback of previous chain contents.
    run_session("t4_done", 40'hDEAD_BEEF_77, 48'h0, 0, 1'b0,
                40'h0, 48'hDEAD_BEEF_7700, 84);

    // 5. Reset at bit 20, then a clean session.
    repeat (2) @(negedge clk);
    preload_model(40'hFF00_FF00_FF);
    exp_rb.push_back(16'hFF00);
    base = rises;
    pulse_start();
    send_word(16'hA5F0, 0);
    send_word(16'h1234, 0);
    n = 0;
    while ((rises - base) < 20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_rises_at_abort", 64'(rises - base), 64'd20);
    chk("t5_clk_high_before", 64'(config_clk), 64'd1);
    sys_reset = 1'b0;
    #1;
    chk("t5_cfg_clk", 64'(config_clk), 64'd0);
    chk("t5_cfg_en", 64'(config_en), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rb_word1_seen", 64'(exp_rb.size()), 64'd0);
    exp_rb.delete();
    exp_done.delete();
    @(negedge clk);
    sys_reset = 1'b1;
    run_session("t5_done", 40'h0F_0F0F_0F0F, 48'hA5F0_1234_C0FF, 0, 1'b0,
                40'hA5F0_1234_C0, 48'h0F0F_0F0F_0F00, 84);

    // 6. start during SHIFT ignored; start right after done restarts.
    run_session("t6_done", 40'hA5F0_1234_C0, 48'h5A0F_EDCB_3F00, 0, 1'b1,
                40'h5A0F_EDCB_3F, 48'hA5F0_1234_C000, 84);
    @(negedge clk);
    start = 1'b1;
    push_expect(16'h5A0F, 16'hEDCB, 16'h3F00, 40'hDEAD_BEEF_77, 84);
    @(negedge clk);
    start = 1'b0;
    chk("t6_restart_ready", 64'(word_ready), 64'd1);
    feed_words(48'hDEAD_BEEF_7777, 0, 1'b0);
    wait_done("t6b_done");

    repeat (4) @(negedge clk);
    chk("rb_queue_empty", 64'(exp_rb.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
